// File: rtl/stack_unit_pkg.sv
// stack_unit_pkg: op encodings and spill engine state for stack_unit
package stack_unit_pkg;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;
  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;
endpackage

// File: rtl/stack_buf.sv
// stack_buf: N x L storage, one write port, top and bottom read ports
module stack_buf #(
  parameter int L = 16,
  parameter int DEP = 3
) (
  input  logic           clk,
  input  logic           we,
  input  logic [DEP-1:0] waddr,
  input  logic [L-1:0]   wdata,
  input  logic [DEP-1:0] taddr,
  output logic [L-1:0]   tdata,
  input  logic [DEP-1:0] baddr,
  output logic [L-1:0]   bdata
);
  logic [L-1:0] mem [2**DEP];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign tdata = mem[taddr];
  assign bdata = mem[baddr];
endmodule

// File: rtl/stack_unit.sv
// stack_unit: circular on-chip stack with optional spill/fill to memory.
// Define STACK_UNIT_SPILL_EN to build the spill/fill engine; otherwise full pushes overwrite the oldest entry.
module stack_unit #(
  parameter int L = 16,
  parameter int DEP = 3,
  parameter logic [L-1:0] BASE = 16'h0100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   op,
  input  logic [L-1:0] din,
  output logic [L-1:0] tos,
  output logic [DEP:0] depth,
  output logic         full,
  output logic         empty,
  output logic         err,
  output logic         stall,
  output logic [L-1:0] mem_addr,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [L-1:0] mem_wdata,
  input  logic [L-1:0] mem_rdata,
  input  logic         mem_ack
);
  import stack_unit_pkg::*;
  localparam logic [DEP:0] NF = {1'b1, {DEP{1'b0}}};
  logic [DEP-1:0] sp, bp, sp_n, bp_n;
  logic [DEP:0] d_n;
  logic [L-1:0] tos_n, tdata, bdata;
  logic push, pop, repl, wrap, under, spill_done, fill_done;
  assign full = depth == NF;
  assign empty = depth == '0;
  assign push = !stall && op == OP_PUSH;
  assign pop = !stall && op == OP_POP && !empty;
  assign repl = !stall && op == OP_REPL && !empty;
  assign under = !stall && (op == OP_POP || op == OP_REPL) && empty;
  assign wrap = push && full;
  // sp addresses the top entry; the bottom entry lives at bp+1, and fills land at bp
  stack_buf #(.L(L), .DEP(DEP)) u_buf (
    .clk,
    .we(push || repl || fill_done),
    .waddr(fill_done ? bp : push ? sp + 1'b1 : sp),
    .wdata(fill_done ? mem_rdata : din),
    .taddr(sp - 1'b1),
    .tdata,
    .baddr(bp + 1'b1),
    .bdata
  );
  always_comb begin
    sp_n = push ? sp + 1'b1 : pop ? sp - 1'b1 : sp;
    bp_n = (wrap || spill_done) ? bp + 1'b1 : fill_done ? bp - 1'b1 : bp;
    d_n = ((push && !full) || fill_done) ? depth + 1'b1 : (pop || spill_done) ? depth - 1'b1 : depth;
    tos_n = (push || repl) ? din : pop ? (d_n == '0 ? '0 : tdata) : (fill_done && empty) ? mem_rdata : tos;
  end
  always_ff @(posedge clk)
    if (reset) begin
      sp <= '0;
      bp <= '0;
      depth <= '0;
      tos <= '0;
      err <= 1'b0;
    end else begin
      sp <= sp_n;
      bp <= bp_n;
      depth <= d_n;
      tos <= tos_n;
      err <= err || under || wrap;
    end
`ifdef STACK_UNIT_SPILL_EN
  state_t state;
  logic [L-1:0] mptr, mptr_n;
  logic go_spill, go_fill;
  assign spill_done = state == SPILL && mem_ack;
  assign fill_done = state == FILL && mem_ack;
  assign mptr_n = spill_done ? mptr + 1'b1 : fill_done ? mptr - 1'b1 : mptr;
  // decide on post-op occupancy so a push can never land on a full buffer
  assign go_spill = d_n == NF;
  assign go_fill = !go_spill && d_n[DEP:1] == '0 && mptr_n != BASE;
  assign stall = state != IDLE;
  assign mem_wdata = state == SPILL ? bdata : '0;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      mptr <= BASE;
      mem_addr <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
    end else begin
      mptr <= mptr_n;
      if (state == IDLE || mem_ack) begin
        state <= go_spill ? SPILL : go_fill ? FILL : IDLE;
        mem_wr <= go_spill;
        mem_rd <= go_fill;
        mem_addr <= go_spill ? mptr_n : go_fill ? mptr_n - 1'b1 : '0;
      end
    end
`else
  logic unused;
  assign unused = mem_ack ^ (^bdata) ^ (^BASE);
  assign spill_done = 1'b0;
  assign fill_done = 1'b0;
  assign stall = 1'b0;
  assign mem_addr = '0;
  assign mem_rd = 1'b0;
  assign mem_wr = 1'b0;
  assign mem_wdata = '0;
`endif
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed checks of stack_unit with L=16, DEP=2 (spill tests when STACK_UNIT_SPILL_EN is defined)
module tb_stack_unit;
  import stack_unit_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] op = OP_NONE;
  logic [15:0] din = '0;
  logic [15:0] tos, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [2:0] depth;
  logic full, empty, err, stall, mem_rd, mem_wr;
  logic mem_ack = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  stack_unit #(.L(16), .DEP(2), .BASE(16'h0100)) dut (
    .clk(clk), .reset(reset), .op(op), .din(din), .tos(tos), .depth(depth),
    .full(full), .empty(empty), .err(err), .stall(stall), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );
  always #5 clk = ~clk;
  task automatic do_op(input logic [1:0] o, input logic [15:0] d);
    op = o;
    din = d;
    @(posedge clk); #1;
    op = OP_NONE;
  endtask
  task automatic apply_reset();
    reset = 1'b1;
    op = OP_NONE;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic test_reset();
    apply_reset();
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth got %0d want 0", depth); end
    n_checks++; if (tos !== 16'h0) begin n_fail++; $display("FAIL reset_tos got %h want 0000", tos); end
    n_checks++; if ({empty, full, err, stall} !== 4'b1000) begin n_fail++; $display("FAIL reset_flags got %b want 1000", {empty, full, err, stall}); end
    n_checks++; if ({mem_rd, mem_wr, mem_addr} !== 18'h0) begin n_fail++; $display("FAIL reset_mem got rd=%b wr=%b addr=%h want 0 0 0000", mem_rd, mem_wr, mem_addr); end
  endtask
  task automatic test_push_pop();
    apply_reset();
    do_op(OP_PUSH, 16'h1111);
    n_checks++; if (tos !== 16'h1111 || depth !== 3'd1) begin n_fail++; $display("FAIL push1 got tos=%h depth=%0d want 1111 1", tos, depth); end
    do_op(OP_PUSH, 16'h2222);
    do_op(OP_PUSH, 16'h3333);
    n_checks++; if (tos !== 16'h3333 || depth !== 3'd3) begin n_fail++; $display("FAIL push3 got tos=%h depth=%0d want 3333 3", tos, depth); end
    do_op(OP_POP, 16'h0);
    n_checks++; if (tos !== 16'h2222 || depth !== 3'd2) begin n_fail++; $display("FAIL pop1 got tos=%h depth=%0d want 2222 2", tos, depth); end
    do_op(OP_POP, 16'h0);
    n_checks++; if (tos !== 16'h1111 || depth !== 3'd1) begin n_fail++; $display("FAIL pop2 got tos=%h depth=%0d want 1111 1", tos, depth); end
    do_op(OP_POP, 16'h0);
    n_checks++; if (tos !== 16'h0 || empty !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL pop_empty got tos=%h empty=%b err=%b want 0000 1 0", tos, empty, err); end
  endtask
  task automatic test_replace_underflow();
    apply_reset();
    do_op(OP_REPL, 16'h5555);
    n_checks++; if (err !== 1'b1 || depth !== 3'd0 || tos !== 16'h0) begin n_fail++; $display("FAIL repl_empty got err=%b depth=%0d tos=%h want 1 0 0000", err, depth, tos); end
    apply_reset();
    do_op(OP_PUSH, 16'h00AA);
    do_op(OP_PUSH, 16'h00BB);
    do_op(OP_REPL, 16'hBEEF);
    n_checks++; if (tos !== 16'hBEEF || depth !== 3'd2) begin n_fail++; $display("FAIL repl got tos=%h depth=%0d want beef 2", tos, depth); end
    do_op(OP_POP, 16'h0);
    n_checks++; if (tos !== 16'h00AA || depth !== 3'd1) begin n_fail++; $display("FAIL repl_pop got tos=%h depth=%0d want 00aa 1", tos, depth); end
    do_op(OP_POP, 16'h0);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL repl_noerr got err=%b want 0", err); end
    do_op(OP_POP, 16'h0);
    n_checks++; if (err !== 1'b1 || depth !== 3'd0 || tos !== 16'h0) begin n_fail++; $display("FAIL underflow got err=%b depth=%0d tos=%h want 1 0 0000", err, depth, tos); end
    do_op(OP_PUSH, 16'h0077);
    n_checks++; if (err !== 1'b1 || tos !== 16'h0077) begin n_fail++; $display("FAIL err_sticky got err=%b tos=%h want 1 0077", err, tos); end
  endtask
  task automatic test_back_to_back();
    apply_reset();
    do_op(OP_PUSH, 16'h0007);
    do_op(OP_PUSH, 16'h0008);
    n_checks++; if (tos !== 16'h0008 || depth !== 3'd2) begin n_fail++; $display("FAIL b2b_push got tos=%h depth=%0d want 0008 2", tos, depth); end
    do_op(OP_POP, 16'h0);
    do_op(OP_PUSH, 16'h0009);
    n_checks++; if (tos !== 16'h0009 || depth !== 3'd2) begin n_fail++; $display("FAIL b2b_poppush got tos=%h depth=%0d want 0009 2", tos, depth); end
    do_op(OP_REPL, 16'h000A);
    do_op(OP_POP, 16'h0);
    n_checks++; if (tos !== 16'h0007 || depth !== 3'd1 || err !== 1'b0) begin n_fail++; $display("FAIL b2b_end got tos=%h depth=%0d err=%b want 0007 1 0", tos, depth, err); end
  endtask
`ifndef STACK_UNIT_SPILL_EN
  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 4; i++) do_op(OP_PUSH, 16'(i));
    n_checks++; if (full !== 1'b1 || err !== 1'b0 || tos !== 16'h4) begin n_fail++; $display("FAIL fill4 got full=%b err=%b tos=%h want 1 0 0004", full, err, tos); end
    do_op(OP_PUSH, 16'h5);
    n_checks++; if (err !== 1'b1 || depth !== 3'd4 || tos !== 16'h5) begin n_fail++; $display("FAIL overflow got err=%b depth=%0d tos=%h want 1 4 0005", err, depth, tos); end
    n_checks++; if ({stall, mem_rd, mem_wr, mem_addr, mem_wdata} !== 35'h0) begin n_fail++; $display("FAIL mem_tied got nonzero mem outputs addr=%h wdata=%h", mem_addr, mem_wdata); end
    for (int i = 4; i >= 2; i--) begin
      do_op(OP_POP, 16'h0);
      n_checks++; if (tos !== 16'(i) || depth !== 3'(i - 1)) begin n_fail++; $display("FAIL ovf_pop%0d got tos=%h depth=%0d want %h %0d", i, tos, depth, 16'(i), i - 1); end
    end
    do_op(OP_POP, 16'h0);
    n_checks++; if (empty !== 1'b1 || err !== 1'b1 || tos !== 16'h0) begin n_fail++; $display("FAIL ovf_empty got empty=%b err=%b tos=%h want 1 1 0000", empty, err, tos); end
  endtask
`else
  task automatic test_spill_fill();
    apply_reset();
    for (int i = 1; i <= 4; i++) do_op(OP_PUSH, 16'(i));
    n_checks++; if (stall !== 1'b1 || mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'h0100 || mem_wdata !== 16'h1) begin n_fail++; $display("FAIL spill_start got stall=%b wr=%b rd=%b addr=%h wdata=%h want 1 1 0 0100 0001", stall, mem_wr, mem_rd, mem_addr, mem_wdata); end
    op = OP_PUSH;
    din = 16'h0099;
    repeat (2) @(posedge clk);
    #1 op = OP_NONE;
    n_checks++; if (depth !== 3'd4 || stall !== 1'b1 || tos !== 16'h4) begin n_fail++; $display("FAIL spill_hold got depth=%0d stall=%b tos=%h want 4 1 0004", depth, stall, tos); end
    mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    n_checks++; if (depth !== 3'd3 || stall !== 1'b0 || mem_wr !== 1'b0 || tos !== 16'h4) begin n_fail++; $display("FAIL spill_ack got depth=%0d stall=%b wr=%b tos=%h want 3 0 0 0004", depth, stall, mem_wr, tos); end
    do_op(OP_POP, 16'h0);
    n_checks++; if (depth !== 3'd2 || tos !== 16'h3 || stall !== 1'b0) begin n_fail++; $display("FAIL sp_pop1 got depth=%0d tos=%h stall=%b want 2 0003 0", depth, tos, stall); end
    do_op(OP_POP, 16'h0);
    n_checks++; if (depth !== 3'd1 || tos !== 16'h2 || stall !== 1'b1 || mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0100) begin n_fail++; $display("FAIL fill_start got depth=%0d tos=%h stall=%b rd=%b wr=%b addr=%h want 1 0002 1 1 0 0100", depth, tos, stall, mem_rd, mem_wr, mem_addr); end
    @(posedge clk); #1;
    mem_rdata = 16'h0001;
    mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    n_checks++; if (depth !== 3'd2 || stall !== 1'b0 || mem_rd !== 1'b0 || tos !== 16'h2) begin n_fail++; $display("FAIL fill_ack got depth=%0d stall=%b rd=%b tos=%h want 2 0 0 0002", depth, stall, mem_rd, tos); end
    do_op(OP_REPL, 16'hBEEF);
    n_checks++; if (tos !== 16'hBEEF || depth !== 3'd2) begin n_fail++; $display("FAIL sp_repl got tos=%h depth=%0d want beef 2", tos, depth); end
    do_op(OP_POP, 16'h0);
    n_checks++; if (tos !== 16'h0001 || depth !== 3'd1 || stall !== 1'b0) begin n_fail++; $display("FAIL filled_data got tos=%h depth=%0d stall=%b want 0001 1 0", tos, depth, stall); end
    do_op(OP_POP, 16'h0);
    do_op(OP_POP, 16'h0);
    n_checks++; if (err !== 1'b1 || depth !== 3'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL sp_underflow got err=%b depth=%0d stall=%b want 1 0 0", err, depth, stall); end
  endtask
  task automatic test_reset_in_spill();
    apply_reset();
    for (int i = 1; i <= 4; i++) do_op(OP_PUSH, 16'(i));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    n_checks++; if (mem_wr !== 1'b0 || stall !== 1'b0 || depth !== 3'd0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_spill got wr=%b stall=%b depth=%0d err=%b want 0 0 0 0", mem_wr, stall, depth, err); end
    for (int i = 1; i <= 4; i++) do_op(OP_PUSH, 16'(i + 16));
    n_checks++; if (mem_wr !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 16'h0011) begin n_fail++; $display("FAIL rst_mptr got wr=%b addr=%h wdata=%h want 1 0100 0011", mem_wr, mem_addr, mem_wdata); end
  endtask
`endif
  initial begin
    test_reset();
    test_push_pop();
    test_replace_underflow();
    test_back_to_back();
`ifndef STACK_UNIT_SPILL_EN
    test_overflow();
`else
    test_spill_fill();
    test_reset_in_spill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
